// File: rtl/lmg_script.sv
// lmg_script: scriptable legal-move-generator stand-in streaming preloaded words into a FIFO
// Optional LMG_MVCOUNT_EN adds mv_count, a running count of valid moves written in the current stream.
module lmg_script #(
  parameter int MPW = 8,
  parameter int OUT_W = 160,
  parameter int DEPTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_en,
  input  logic [$clog2(DEPTH)-1:0]   ld_addr,
  input  logic [OUT_W-1:0]           ld_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_words,
  input  logic                       rden,
  output logic [OUT_W-1:0]           fifoOut,
  output logic                       fifoEmpty,
  output logic                       fifoFull,
  output logic                       busy,
  output logic                       done,
`ifdef LMG_MVCOUNT_EN
  output logic [$clog2(DEPTH*MPW+1)-1:0] mv_count,
`endif
  output logic [$clog2(DEPTH):0]     words_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] MASK = {OUT_W{1'b1}} >> (OUT_W - MPW * 19);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [OUT_W-1:0] tbl [DEPTH];
  logic [OUT_W-1:0] fmem [FIFO_DEPTH];
  logic [NW-1:0] n_q, idx, n_clamp;
  logic [FAW-1:0] wp, rp;
  logic [FAW:0] cnt, cnt_n;
  logic [OUT_W-1:0] wdata;
  logic go, wr, rd, last;
  always_comb begin
    n_clamp = num_words > NW'(DEPTH) ? NW'(DEPTH) : num_words;
    go = start && state != EMIT;
    wr = state == EMIT && !fifoFull;
    rd = rden && !fifoEmpty;
    last = idx == n_q - 1'b1;
    wdata = tbl[idx[AW-1:0]];
    cnt_n = cnt + {{FAW{1'b0}}, wr} - {{FAW{1'b0}}, rd};
    state_n = go ? (n_clamp == '0 ? DONE : EMIT) : (wr && last) ? DONE : state;
  end
  assign busy = state == EMIT;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      n_q <= '0;
      idx <= '0;
      words_out <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      fifoEmpty <= 1'b1;
      fifoFull <= 1'b0;
      fifoOut <= '0;
    end else begin
      state <= state_n;
      if (go) begin
        n_q <= n_clamp;
        idx <= '0;
        words_out <= '0;
      end else if (wr) begin
        idx <= idx + 1'b1;
        words_out <= words_out + 1'b1;
      end
      if (wr) wp <= wp + 1'b1;
      if (rd) begin
        rp <= rp + 1'b1;
        fifoOut <= fmem[rp];
      end
      cnt <= cnt_n;
      fifoEmpty <= cnt_n == '0;
      fifoFull <= cnt_n == (FAW+1)'(FIFO_DEPTH);
    end
  end
  // Storage arrays carry no reset: the script table must survive reset.
  always_ff @(posedge clk) begin
    if (wr) fmem[wp] <= wdata;
    if (ld_en && state != EMIT) tbl[ld_addr] <= ld_data & MASK;
  end
`ifdef LMG_MVCOUNT_EN
  localparam int CW = $clog2(DEPTH*MPW+1);
  logic [CW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int k = 0; k < MPW; k++) pc = pc + CW'(!wdata[19*k+18]);
  end
  always_ff @(posedge clk) begin
    if (reset || go) mv_count <= '0;
    else if (wr) mv_count <= mv_count + pc;
  end
`endif
endmodule

// File: tb/tb_lmg_script.sv
// tb_lmg_script: directed scoreboard bench for lmg_script (DEPTH=16, FIFO_DEPTH=4)
module tb_lmg_script;
  logic clk = 0, reset = 1, ld_en = 0, start = 0, rden = 0;
  logic [3:0] ld_addr = 0;
  logic [159:0] ld_data = 0;
  logic [4:0] num_words = 0;
  logic [159:0] fifoOut;
  logic fifoEmpty, fifoFull, busy, done;
  logic [4:0] words_out;
`ifdef LMG_MVCOUNT_EN
  logic [7:0] mv_count;
`endif
  int vectors = 0, errs = 0;
  logic [159:0] tbl [16];
  logic [159:0] sb [$];
  localparam logic [159:0] MASK = {8'h0, {152{1'b1}}};

  lmg_script #(.MPW(8), .OUT_W(160), .DEPTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_words(num_words), .rden(rden), .fifoOut(fifoOut),
    .fifoEmpty(fifoEmpty), .fifoFull(fifoFull), .busy(busy), .done(done),
`ifdef LMG_MVCOUNT_EN
    .mv_count(mv_count),
`endif
    .words_out(words_out));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ld(input int a, input logic [159:0] d);
    ld_en = 1;
    ld_addr = a[3:0];
    ld_data = d;
    tick;
    ld_en = 0;
  endtask

  task automatic go(input int n);
    start = 1;
    num_words = n[4:0];
    tick;
    start = 0;
    for (int i = 0; i < (n > 16 ? 16 : n); i++) sb.push_back(tbl[i]);
  endtask

  task automatic pop_chk;
    chk("sb_nonempty", 160'(sb.size() != 0), 160'(1));
    if (sb.size() != 0) chk("pop_word", fifoOut, sb.pop_front());
  endtask

  task automatic drain(input int p);
    int cyc = 0;
    while (!(done && fifoEmpty && sb.size() == 0) && cyc < 400) begin
      rden = (cyc % p == 0) && !fifoEmpty;
      tick;
      if (rden) pop_chk;
      rden = 0;
      cyc++;
    end
    chk("drain_in_budget", 160'(cyc < 400), 160'(1));
    chk("drain_empty", fifoEmpty, 1);
  endtask

  function automatic logic [18:0] mv(input logic [6:0] f, input int fr, input int to);
    return {f, fr[5:0], to[5:0]};
  endfunction

  initial begin
    logic [159:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[19*k +: 19] = mv(7'h00, 8 + k, 16 + k);
    tbl[0] = w;
    for (int k = 0; k < 8; k++) w[19*k +: 19] = mv(7'h01, 8 + k, 24 + k);
    tbl[1] = w;
    w[18:0] = mv(7'h00, 1, 16);
    w[37:19] = mv(7'h00, 1, 18);
    w[56:38] = mv(7'h00, 6, 21);
    w[75:57] = mv(7'h00, 6, 23);
    for (int k = 4; k < 8; k++) w[19*k +: 19] = mv(7'h40, 0, 0);
    tbl[2] = w;
    for (int i = 3; i < 16; i++) tbl[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};

    tick;
    tick;
    reset = 0;
    chk("rst_fifoOut", fifoOut, 0);
    chk("rst_empty", fifoEmpty, 1);
    chk("rst_full", fifoFull, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words_out", words_out, 0);

    for (int i = 0; i < 16; i++) begin
      ld(i, tbl[i]);
      tbl[i] = tbl[i] & MASK;
    end

    go(3);
    chk("t1_busy", busy, 1);
    chk("t1_empty_pre", fifoEmpty, 1);
    tick;
    chk("t1_wo1", words_out, 1);
    chk("t1_nonempty", fifoEmpty, 0);
    tick;
    chk("t1_wo2", words_out, 2);
    tick;
    chk("t1_done", done, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_wo3", words_out, 3);
`ifdef LMG_MVCOUNT_EN
    chk("t1_mv_count", mv_count, 20);
`endif
    drain(1);

    rden = 1;
    tick;
    rden = 0;
    chk("empty_rd_hold", fifoOut, tbl[2]);
    chk("empty_rd_empty", fifoEmpty, 1);

    go(6);
    repeat (4) tick;
    chk("t2_full", fifoFull, 1);
    chk("t2_wo4", words_out, 4);
    repeat (2) tick;
    chk("t2_busy_held", busy, 1);
    chk("t2_wo_hold", words_out, 4);
    drain(3);
    chk("t2_done", done, 1);
    chk("t2_wo6", words_out, 6);

    go(0);
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    chk("n0_wo", words_out, 0);
    chk("n0_empty", fifoEmpty, 1);
`ifdef LMG_MVCOUNT_EN
    chk("n0_mv_count", mv_count, 0);
`endif

    go(20);
    drain(1);
    chk("n20_wo16", words_out, 16);

    go(5);
    tick;
    tick;
    reset = 1;
    tick;
    reset = 0;
    sb.delete();
    chk("mid_rst_empty", fifoEmpty, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wo", words_out, 0);
    go(1);
    drain(1);

    go(4);
    ld(1, ~tbl[1]);
    drain(1);

    go(5);
    tick;
    tick;
    rden = 1;
    tick;
    rden = 0;
    pop_chk;
    chk("sim_nonempty", fifoEmpty, 0);
    chk("sim_notfull", fifoFull, 0);
    tick;
    chk("sim_cnt3", fifoFull, 0);
    tick;
    chk("sim_cnt4", fifoFull, 1);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
